// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared operand bundle and width for the sequential multiplier
package mul_seq_pkg;
  localparam int MUL_WIDTH = 32;
  typedef struct packed {
    logic                 en;
    logic                 signed_en;
    logic [MUL_WIDTH-1:0] opA;
    logic [MUL_WIDTH-1:0] opB;
  } MUL_input_t;
endpackage

// File: rtl/mul_seq_if.sv
// mul_seq_if: execute-stage request/response bundle for the multiplier
interface mul_seq_if;
  import mul_seq_pkg::*;
  MUL_input_t                 in;
  logic                       flush;
  logic                       mul_halt;
  logic                       done;
  logic [2*MUL_WIDTH-1:0]     c;
  modport master (output in, flush, input mul_halt, done, c);
  modport slave (input in, flush, output mul_halt, done, c);
endinterface

// File: rtl/mul_seq.sv
// mul_seq: multicycle shift-add 32x32->64 multiplier (MULT/MULTU), stalls the pipe while iterating
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input logic      clk,
  input logic      reset,
  mul_seq_if.slave bus
);
  localparam int P  = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [P-1:0]    acc_q, acc_d, mcand_q, mcand_d, c_q, c_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic            neg_q, neg_d, done_q, done_d;
  function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? ~v + WIDTH'(1) : v;
  endfunction
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    c_d      = c_q;
    done_d   = 1'b0;
    if (bus.flush) state_d = IDLE;
    else
      case (state_q)
        IDLE:
          if (bus.in.en) begin
            state_d  = BUSY;
            mcand_d  = {{WIDTH{1'b0}}, abs_w(bus.in.opA, bus.in.signed_en)};
            mplier_d = abs_w(bus.in.opB, bus.in.signed_en);
            neg_d    = bus.in.signed_en & (bus.in.opA[WIDTH-1] ^ bus.in.opB[WIDTH-1]);
            acc_d    = '0;
            count_d  = CW'(WIDTH);
          end
        BUSY: begin
          acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          count_d  = count_q - CW'(1);
          state_d  = (count_q == CW'(1)) ? DONE : BUSY;
        end
        DONE: begin
          c_d     = neg_q ? ~acc_q + P'(1) : acc_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      c_q      <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      c_q      <= c_d;
      done_q   <= done_d;
    end
  // DONE still stalls so the consumer only advances once c/done are registered
  assign bus.mul_halt = !reset && !bus.flush && (state_d != IDLE || state_q == DONE);
  assign bus.done     = done_q;
  assign bus.c        = c_q;
endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: directed vectors for mul_seq with hand-computed products and latency
module tb_mul_seq;
  import mul_seq_pkg::*;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  mul_seq_if bus ();
  mul_seq dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, act, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp);
    int d_at = -1;
    int hcnt = 0;
    bus.in = '{en: 1'b1, signed_en: s, opA: a, opB: b};
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.done) begin
        d_at = i;
        chk({tag, " halt_at_done"}, 64'(bus.mul_halt), 64'd0);
        break;
      end
      if (bus.mul_halt) hcnt++;
      @(posedge clk);
      #1;
      bus.in.en  = 1'b0;
      bus.in.opA = $urandom;
      bus.in.opB = $urandom;
    end
    chk({tag, " c"}, bus.c, exp);
    chk({tag, " done_cycle"}, 64'(d_at), 64'd34);
    chk({tag, " halt_cycles"}, 64'(hcnt), 64'd34);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk({tag, " done_pulse"}, 64'(bus.done), 64'd0);
    chk({tag, " c_hold"}, bus.c, exp);
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [63:0] prev;
    int          dones;
    reset = 1'b1;
    bus.in = '0;
    bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst c", bus.c, 64'd0);
    chk("rst done", 64'(bus.done), 64'd0);
    bus.in.en = 1'b1;
    #1;
    chk("rst halt", 64'(bus.mul_halt), 64'd0);
    bus.in.en = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_op("u3x5", 1'b0, 32'd3, 32'd5, 64'h00000000_0000000F);
    run_op("s-3x5", 1'b1, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1);
    run_op("u-3x5", 1'b0, 32'hFFFFFFFD, 32'd5, 64'h00000004_FFFFFFF1);
    run_op("umaxsq", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    run_op("s-1sq", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001);
    run_op("sminsq", 1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
    run_op("sminx1", 1'b1, 32'h80000000, 32'd1, 64'hFFFFFFFF_80000000);
    prev = 64'hFFFFFFFF_80000000;
    bus.in = '{en: 1'b1, signed_en: 1'b0, opA: 32'd7, opB: 32'd9};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      bus.in.en = 1'b0;
    end
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush halt", 64'(bus.mul_halt), 64'd0);
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    @(negedge clk);
    chk("flush idle halt", 64'(bus.mul_halt), 64'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("flush no done", 64'(dones), 64'd0);
    chk("flush c kept", bus.c, prev);
    @(posedge clk);
    #1;
    run_op("u2x2", 1'b0, 32'd2, 32'd2, 64'd4);
    bus.in = '{en: 1'b1, signed_en: 1'b0, opA: 32'd9, opB: 32'd9};
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      bus.in.en = 1'b0;
    end
    reset = 1'b1;
    #1;
    chk("midrst c", bus.c, 64'd0);
    chk("midrst done", 64'(bus.done), 64'd0);
    chk("midrst halt", 64'(bus.mul_halt), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_op("u6x7", 1'b0, 32'd6, 32'd7, 64'd42);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
